// File: rtl/dimswitch_pkg.sv
// Shared types and constants for the dimension-switch PIO arbiter.
// Used by rr_arbiter and dimswitch_arbiter.
package dimswitch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [1:0] DIMSW_ADDR   = 2'd0;
  localparam int         DIMSW_DATA_W = 32;

endpackage

// File: rtl/dimswitch_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after `last`,
// wrapping around to index 0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   id,
  output logic             any_req
);

  logic found;

  // First pass takes requesters above `last`; the second pass only runs when
  // none of them asked, so it naturally covers the wrapped range 0..last.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (IDW'(i) > last)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        id       = IDW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        id       = IDW'(i);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/dimswitch_arbiter.sv
// Round-robin sharing of the write-only dimension-switch PIO among N_REQ cores.
// Optional post-change guard interval: define DIMSWITCH_HOLDOFF_EN.
module dimswitch_arbiter
  import dimswitch_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int IDW            = 2,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_val,
  output logic [N_REQ-1:0]        ack,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic                    cur_value,
  output logic [1:0]              avm_address,
  output logic                    avm_chipselect,
  output logic                    avm_write_n,
  output logic [DIMSW_DATA_W-1:0] avm_writedata
);

  if (N_REQ < 2 || N_REQ > 8 || (1 << IDW) < N_REQ ||
      HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : g_param_check
    $error("dimswitch_arbiter: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             val_q, val_d;
  logic [IDW-1:0]   last_q, last_d;
  logic             cur_value_q, cur_value_d;

`ifdef DIMSWITCH_HOLDOFF_EN
  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       chg_q, chg_d;
`endif

  logic [N_REQ-1:0] arb_grant;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req     (req),
    .last    (last_q),
    .grant   (arb_grant),
    .id      (arb_id),
    .any_req (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    grant_d     = grant_q;
    val_d       = val_q;
    last_d      = last_q;
    cur_value_d = cur_value_q;
`ifdef DIMSWITCH_HOLDOFF_EN
    cnt_d       = cnt_q;
    chg_d       = chg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_WRITE;
          id_d    = arb_id;
          grant_d = arb_grant;
          val_d   = req_val[arb_id];
        end
      end
      ST_WRITE: begin
        cur_value_d = val_q;
        last_d      = id_q;
        state_d     = ST_SETTLE;
`ifdef DIMSWITCH_HOLDOFF_EN
        chg_d       = (val_q != cur_value_q);
`endif
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
`ifdef DIMSWITCH_HOLDOFF_EN
        // HOLD_LOAD is one less than the interval: the cycle that sees zero is the last HOLD cycle.
        if (chg_q) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
`endif
      end
`ifdef DIMSWITCH_HOLDOFF_EN
      ST_HOLD: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      grant_q     <= '0;
      val_q       <= 1'b0;
      last_q      <= IDW'(N_REQ - 1);
      cur_value_q <= 1'b0;
`ifdef DIMSWITCH_HOLDOFF_EN
      cnt_q       <= 8'd0;
      chg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      grant_q     <= grant_d;
      val_q       <= val_d;
      last_q      <= last_d;
      cur_value_q <= cur_value_d;
`ifdef DIMSWITCH_HOLDOFF_EN
      cnt_q       <= cnt_d;
      chg_q       <= chg_d;
`endif
    end
  end

  // Decoded from the state register only, so an async reset drops the strobe at once.
  logic in_write;
  assign in_write = (state_q == ST_WRITE);

  assign ack            = in_write ? grant_q : '0;
  assign grant_id       = id_q;
  assign busy           = (state_q != ST_IDLE);
  assign cur_value      = cur_value_q;
  assign avm_address    = DIMSW_ADDR;
  assign avm_chipselect = in_write;
  assign avm_write_n    = ~in_write;
  assign avm_writedata  = {{(DIMSW_DATA_W-1){1'b0}}, (in_write ? val_q : cur_value_q)};

endmodule

// File: tb/tb_dimswitch_arbiter.sv
// Randomized scoreboard bench for dimswitch_arbiter; honours DIMSWITCH_HOLDOFF_EN
// when defined for the whole build.
module tb_dimswitch_arbiter;

  localparam int N_REQ   = 4;
  localparam int IDW     = 2;
  localparam int HOLDOFF = 4;
  localparam int EW      = 32 + IDW + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] req_val = '0;
  logic [N_REQ-1:0] ack;
  logic [IDW-1:0]   grant_id;
  logic             busy;
  logic             cur_value;
  logic [1:0]       avm_address;
  logic             avm_chipselect;
  logic             avm_write_n;
  logic [31:0]      avm_writedata;

  dimswitch_arbiter #(
    .N_REQ          (N_REQ),
    .IDW            (IDW),
    .HOLDOFF_CYCLES (HOLDOFF)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_val        (req_val),
    .ack            (ack),
    .grant_id       (grant_id),
    .busy           (busy),
    .cur_value      (cur_value),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared bench state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  bit exp_busy = 1'b0;
  logic mon_val = 1'b0;
  logic [EW-1:0] exp_q[$];

  // reference model: requester intent plus abstract arbiter state
  logic [N_REQ-1:0] want = '0;
  logic [N_REQ-1:0] want_val = '0;
  bit   [N_REQ-1:0] gact = '0;
  int               gcyc [N_REQ];
  int               mlast = N_REQ - 1;
  logic             mcur = 1'b0;
  int               next_free = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver + model ----------------
  task automatic run_cycles(input int n, input bit rnd);
    logic [N_REQ-1:0] r;
    int pick;
    bit found;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rnd) begin
        for (int i = 0; i < N_REQ; i++)
          if ($urandom_range(0, 3) == 0) want[i] = ~want[i];
        want_val = N_REQ'($urandom);
      end
      exp_busy = (cyc < next_free);
      r = '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (gact[i]) begin
          if (cyc == gcyc[i] + 1) r[i] = 1'b1;
          else begin
            r[i] = 1'b0;
            gact[i] = 1'b0;
          end
        end else begin
          r[i] = want[i];
        end
      end
      req     = r;
      req_val = want_val;
      if (cyc >= next_free && r != '0) begin
        found = 1'b0;
        pick  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
          int idx;
          idx = (mlast + k) % N_REQ;
          if (!found && r[idx]) begin
            found = 1'b1;
            pick  = idx;
          end
        end
        exp_q.push_back({32'(cyc + 1), IDW'(pick), want_val[pick]});
        gact[pick] = 1'b1;
        gcyc[pick] = cyc;
        next_free  = cyc + 3;
`ifdef DIMSWITCH_HOLDOFF_EN
        if (want_val[pick] != mcur) next_free += HOLDOFF;
`endif
        mcur  = want_val[pick];
        mlast = pick;
      end
    end
  endtask

  task automatic do_reset(input bit already_low);
    mon_en = 1'b0;
    if (!already_low) reset_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
      req     = N_REQ'($urandom);
      req_val = N_REQ'($urandom);
    end
    reset_n   = 1'b1;
    req       = '0;
    want      = '0;
    gact      = '0;
    mlast     = N_REQ - 1;
    mcur      = 1'b0;
    next_free = cyc;
    exp_busy  = 1'b0;
    mon_val   = 1'b0;
    exp_q.delete();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_write_n", 32'(avm_write_n), 32'd1);
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_cur", 32'(cur_value), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
    mon_en = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("address", 32'(avm_address), 32'd0);
      if (avm_chipselect || !avm_write_n || ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(ack), 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("write_cyc", 32'(cyc), e[EW-1 -: 32]);
          chk("ack", 32'(ack), 32'(N_REQ'(1) << e[IDW:1]));
          chk("grant_id", 32'(grant_id), 32'(e[IDW:1]));
          chk("cs", 32'(avm_chipselect), 32'd1);
          chk("write_n", 32'(avm_write_n), 32'd0);
          chk("wdata", avm_writedata, {31'd0, e[0]});
          mon_val = e[0];
        end
      end else begin
        chk("shadow", 32'(cur_value), 32'(mon_val));
        chk("idle_wdata", avm_writedata, {31'd0, mon_val});
        if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("missing_write", 32'(cyc), e[EW-1 -: 32]);
        end
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    for (int i = 0; i < N_REQ; i++) gcyc[i] = 0;
    do_reset(1'b1);

    // single request from requester 2 with value 1
    want = 4'b0100; want_val = 4'b0100;
    run_cycles(1, 1'b0);
    want = '0;
    run_cycles(6, 1'b0);

    // full contention after reset: order 0,1,2,3
    do_reset(1'b0);
    want = 4'b1111; want_val = 4'b0101;
    run_cycles(12, 1'b0);
    want = '0;
    run_cycles(6, 1'b0);

    // wrap-around: grant 3 first, then 0 and 3 contend
    do_reset(1'b0);
    want = 4'b1000; want_val = 4'b1000;
    run_cycles(1, 1'b0);
    want = 4'b1001; want_val = 4'b0001;
    run_cycles(20, 1'b0);
    want = '0;
    run_cycles(6, 1'b0);

    // value-change followed by pending req, then same-value writes
    do_reset(1'b0);
    want = 4'b0011; want_val = 4'b0011;
    run_cycles(20, 1'b0);
    want = '0;
    run_cycles(8, 1'b0);

    // async reset in the middle of a WRITE
    want = 4'b0001; want_val = 4'b0001;
    run_cycles(10, 1'b0);
    while (!(gact[0] && cyc == gcyc[0])) run_cycles(1, 1'b0);
    @(posedge clk);
    #3;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_cs", 32'(avm_chipselect), 32'd0);
    chk("midrst_write_n", 32'(avm_write_n), 32'd1);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    do_reset(1'b1);
    want = 4'b1001; want_val = 4'b1000;
    run_cycles(12, 1'b0);
    want = '0;
    run_cycles(6, 1'b0);

    // randomized traffic
    run_cycles(600, 1'b1);
    want = '0;
    run_cycles(30, 1'b0);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dimswitch_arbiter.md
Name: dimswitch_arbiter

Overview:
- Shares the single write-only dimension-switch PIO (Avalon-MM slave s1: 2-bit address, chipselect, write_n, 32-bit writedata, 1-bit output latched from writedata[0]) among N_REQ requesting cores of the 2x2 NovaCORE fabric.
- Arbitrates requests round-robin and issues exactly one zero-wait-state Avalon write per grant.
- Keeps a shadow copy of the switch value and returns a one-cycle acknowledge to the winning requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; must satisfy 2**IDW >= N_REQ.
- HOLDOFF_CYCLES, 16, guard cycles after a value change (used only with the optional feature; range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level.
- req_val  in  N_REQ  per-requester requested switch value, bit i belongs to requester i.
- ack  out  N_REQ  one-hot, one-cycle completion pulse.
- grant_id  out  IDW  index of the requester being served; valid while busy=1.
- busy  out  1  high in every state except IDLE.
- cur_value  out  1  shadow of the PIO output.
- avm_address  out  2  PIO address; constant 0.
- avm_chipselect  out  1  PIO chipselect.
- avm_write_n  out  1  PIO write strobe, active low.
- avm_writedata  out  32  {31'b0, latched value}.

Behaviour:
- Reset (async, reset_n=0), entered from any state, including mid-write:
  - FSM goes to IDLE.
  - ack=0, busy=0, grant_id=0, cur_value=0 (matches the PIO reset value).
  - avm_chipselect=0, avm_write_n=1, avm_writedata=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, WRITE, SETTLE, plus HOLD when the optional feature is enabled.
- IDLE: if req!=0, pick the first set bit scanning from last+1 upward with wrap-around. On that edge:
  - latch id and val=req_val[id];
  - go to WRITE.
- WRITE (exactly 1 cycle):
  - avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata[0]=val.
  - ack[id]=1.
  - At the end of the cycle: cur_value<=val, last<=id, go to SETTLE.
- SETTLE (exactly 1 cycle): req is ignored, which gives requesters one cycle to drop req after ack. Next state is IDLE (or HOLD, see the optional feature).
- Latency: req sampled high in IDLE cycle T gives WRITE and ack in T+1. Minimum spacing between grants is 3 cycles.
- Handshake rules:
  - A requester holds req until it sees ack and must drop req in the cycle after ack.
  - If req is still high in the IDLE cycle after SETTLE, it is a new request.
  - Dropping req before it is granted withdraws the request with no effect.
  - req and req_val changes after the IDLE latch edge do not affect the write in progress.
- Simultaneous requests are resolved purely by round-robin. Starvation bound: each requester waits at most N_REQ-1 grants.
- A write is issued even when val==cur_value. The ack is always produced.
- Outside WRITE: avm_chipselect=0, avm_write_n=1, avm_writedata holds the last written value.

Optional Feature:
- Macro: DIMSWITCH_HOLDOFF_EN.
- Defined: after SETTLE, if the completed write changed cur_value, enter HOLD for HOLDOFF_CYCLES cycles, counted by an 8-bit down-counter.
  - During HOLD: busy=1 and req is ignored. The FSM returns to IDLE when the counter reaches 0.
  - A write that does not change the value goes SETTLE->IDLE directly.
  - Reset clears the counter.
- Undefined: no HOLD state, no counter logic; SETTLE->IDLE always. HOLDOFF_CYCLES is unused.

Decomposition:
- Shared package dimswitch_pkg:
  - FSM state enum (IDLE, WRITE, SETTLE, HOLD);
  - DIMSW_ADDR=2'd0;
  - DIMSW_DATA_W=32.
- One sub-module, rr_arbiter: combinational round-robin picker. Inputs are the req vector and the last pointer; outputs are a one-hot grant, an encoded id, and any_req. It is parameterised by N_REQ and IDW.

Test Plan:
- Reset: hold reset_n=0 with random req, release -> busy=0, ack=0, avm_write_n=1, avm_chipselect=0, cur_value=0, all at the first edge.
- Single request: req=4'b0100, req_val[2]=1 at T -> at T+1 chipselect=1, write_n=0, address=0, writedata=32'h1, ack=4'b0100; cur_value=1 at T+2.
- Contention: req=4'b1111 held, each requester dropping req one cycle after its ack -> grant order 0,1,2,3, each write 3 cycles apart, exactly one ack each.
- Round-robin wrap: after a grant to 3, req=4'b1001 -> requester 0 is granted before 3; after a grant to 0, req=4'b1001 -> requester 3 is granted first.
- Reset mid-op: assert reset_n=0 during WRITE -> chipselect drops and write_n rises asynchronously, ack=0, next grant again favours requester 0.
- DIMSWITCH_HOLDOFF_EN, HOLDOFF_CYCLES=4: a value change 0->1 followed by a pending req -> next WRITE exactly 7 cycles after the first (WRITE, SETTLE, 4xHOLD, IDLE). A same-value write followed by a pending req -> next WRITE 3 cycles later.
